// File: rtl/bitbrick_seq_ctrl_if.sv
// bitbrick_seq_ctrl_if: request/result handshake bundle for the bitbrick multiply sequencer.
//   in_valid/in_ready   request handshake carrying a, b (8b), sign_a, sign_b, prec (2b)
//   out_valid/out_ready result handshake carrying p (ACC_W, signed)
//   master = requester/consumer side, slave = sequencer side
interface bitbrick_seq_ctrl_if #(parameter int ACC_W = 16);
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       a;
   logic [7:0]       b;
   logic             sign_a;
   logic             sign_b;
   logic [1:0]       prec;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] p;
   modport master (output in_valid, a, b, sign_a, sign_b, prec, out_ready,
                   input  in_ready, out_valid, p);
   modport slave  (input  in_valid, a, b, sign_a, sign_b, prec, out_ready,
                   output in_ready, out_valid, p);
endinterface

// File: rtl/bitbrick_seq_ctrl.sv
// bitbrick_seq_ctrl: temporal 2-bit-chunk multiply sequencer around one 2x2 bitbrick.
//   clk    rising-edge clock
//   reset  synchronous active-low reset
//   bus    bitbrick_seq_ctrl_if.slave (request a/b/sign/prec in, signed product p out)
//   ACC_W  accumulator/result width (>= 16, must match the interface ACC_W)
//   Optional macro BITBRICK_ZERO_SKIP_EN: a zero masked operand skips RUN and reports p = 0.
module bitbrick_seq_ctrl #(
   parameter int ACC_W = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   bitbrick_seq_ctrl_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t                  state;
   logic [7:0]              a_r, b_r;
   logic                    sa, sb;
   logic [1:0]              c, c_in, i, j;
   logic [1:0]              x, y;
   logic signed [2:0]       xs, ys;
   logic signed [5:0]       prod;
   logic signed [ACC_W-1:0] acc, acc_next;
   logic                    last;
`ifdef BITBRICK_ZERO_SKIP_EN
   logic [7:0]              mask;
   logic                    zero_op;
`endif
   // c holds C-1, the index of the top (sign-carrying) chunk; reserved prec acts as 8-bit
   always_comb begin
      c_in     = bus.prec == 2'b00 ? 2'd0 : bus.prec == 2'b01 ? 2'd1 : 2'd3;
      x        = a_r[2*i +: 2];
      y        = b_r[2*j +: 2];
      xs       = {sa & (i == c) & x[1], x};
      ys       = {sb & (j == c) & y[1], y};
      prod     = xs * ys;
      acc_next = acc + ({{(ACC_W-6){prod[5]}}, prod} << (2*(i+j)));
      last     = (i == c) && (j == c);
`ifdef BITBRICK_ZERO_SKIP_EN
      mask     = bus.prec == 2'b00 ? 8'h03 : bus.prec == 2'b01 ? 8'h0F : 8'hFF;
      zero_op  = ((bus.a & mask) == 8'h00) || ((bus.b & mask) == 8'h00);
`endif
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= IDLE;
         bus.in_ready  <= 1'b1;
         bus.out_valid <= 1'b0;
         bus.p         <= '0;
         acc           <= '0;
         i             <= 2'd0;
         j             <= 2'd0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               a_r          <= bus.a;
               b_r          <= bus.b;
               sa           <= bus.sign_a;
               sb           <= bus.sign_b;
               c            <= c_in;
               acc          <= '0;
               i            <= 2'd0;
               j            <= 2'd0;
               bus.in_ready <= 1'b0;
`ifdef BITBRICK_ZERO_SKIP_EN
               state         <= zero_op ? DONE : RUN;
               bus.out_valid <= zero_op;
               if (zero_op) bus.p <= '0;
`else
               state        <= RUN;
`endif
            end
            RUN: begin
               acc <= acc_next;
               j   <= j == c ? 2'd0 : j + 2'd1;
               if (j == c) i <= i + 2'd1;
               if (last) begin
                  state         <= DONE;
                  bus.out_valid <= 1'b1;
                  bus.p         <= acc_next;
               end
            end
            DONE: if (bus.out_ready) begin
               state         <= IDLE;
               bus.out_valid <= 1'b0;
               bus.in_ready  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
